// File: rtl/apb3_requester_arbiter.sv
// Round-robin arbiter sharing one APB3 requester port among several clients.
// Each client gets a valid/ready request handshake and a one-cycle response pulse.
module apb3_requester_arbiter #(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NumRequesters-1:0]              req_valid_i,
  input  logic [NumRequesters-1:0]              req_write_i,
  input  logic [NumRequesters*AddressWidth-1:0] req_addr_i,
  input  logic [NumRequesters*DataWidth-1:0]    req_wdata_i,
  output logic [NumRequesters-1:0]              req_ready_o,
  output logic [NumRequesters-1:0]              rsp_valid_o,
  output logic [DataWidth-1:0]                  rsp_rdata_o,
  output logic                                  rsp_error_o,
  output logic [AddressWidth-1:0]               paddr_o,
  output logic                                  pselx_o,
  output logic                                  penable_o,
  output logic                                  pwrite_o,
  output logic [DataWidth-1:0]                  pwdata_o,
  input  logic [DataWidth-1:0]                  prdata_i,
  input  logic                                  pready_i,
  input  logic                                  pslverr_i
);

  localparam int GW = $clog2(NumRequesters);
  localparam int CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int TL = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                   state_q, state_d;
  logic [GW-1:0]            gnt_q, gnt_d;
  logic [GW-1:0]            last_q, last_d;
  logic [AddressWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]     wdata_q, wdata_d;
  logic                     write_q, write_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NumRequesters-1:0] rsp_q, rsp_d;
  logic [DataWidth-1:0]     rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic                     found;
  logic [GW-1:0]            pick;
  int                       idx;

  function automatic logic [NumRequesters-1:0] onehot(
    input logic [GW-1:0] i
  );
    return NumRequesters'(1) << i;
  endfunction

  // Scan upward from the client after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NumRequesters; k++) begin
      idx = (int'(last_q) + k) % NumRequesters;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign req_ready_o =
    (state_q == IDLE && found) ? onehot(pick) : '0;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    rsp_d   = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = req_addr_i[int'(pick)*AddressWidth +: AddressWidth];
          wdata_d = req_wdata_i[int'(pick)*DataWidth +: DataWidth];
          write_d = req_write_i[pick];
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          rdata_d = write_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          rsp_d   = onehot(gnt_q);
          cnt_d   = '0;
          state_d = IDLE;
        end else if (TimeoutCycles != 0 && cnt_q == CW'(TL)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          rsp_d   = onehot(gnt_q);
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NumRequesters - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rsp_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign pselx_o     = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign rsp_valid_o = rsp_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = err_q;

endmodule
